core_run_monitor: RTL
=====================

Name: core_run_monitor

Overview:
Synthesizable run monitor for riscv_core bring-up and custom-instruction regression. It snoops the core's fetch PC and data-write bus and emits a periodic PC sample stream. It captures NUM_RESULTS result words written to a result window. It terminates the run on a completion marker write, a sample-count timeout or a stuck-PC hang. It sits beside u_dut in benches and FPGA builds, fed from the mem_d write path, and replaces ad-hoc hierarchical peeking.

Parameters:
SAMPLE_INTERVAL, 100, cycles between PC samples (>=2)
MAX_SAMPLES, 500, samples taken before the timeout terminal state
HANG_SAMPLES, 8, consecutive identical sampled PCs that declare a hang (>=1)
MARKER_ADDR, 32'h80009030, word address of the completion marker
MARKER_VALUE, 32'hDEADBEEF, value that signals completion
RESULT_BASE, 32'h80009000, word address of result word 0
NUM_RESULTS, 2, number of 32-bit result slots (1..16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start_i  in  1  one-cycle pulse; IDLE->RUN
clear_i  in  1  one-cycle pulse; any state->IDLE, clears all status
pc_valid_i  in  1  qualifies pc_i
pc_i  in  32  executing PC, e.g. exec0 opcode_pc
d_addr_i  in  32  data-bus address
d_data_wr_i  in  32  data-bus write data
d_wr_i  in  4  byte write enables
d_accept_i  in  1  write accepted this cycle
state_o  out  3  0 IDLE, 1 RUN, 2 DONE, 3 TIMEOUT, 4 HANG
done_o  out  1  level, state==DONE
timeout_o  out  1  level, state==TIMEOUT
hang_o  out  1  level, state==HANG
cycle_count_o  out  32  cycles spent in RUN, saturating
sample_valid_o  out  1  one-cycle pulse per sample
sample_pc_o  out  32  sampled PC
sample_idx_o  out  16  1-based sample number
result_data_o  out  32*NUM_RESULTS  captured result words; slot k at bits [32k+31:32k]
result_valid_o  out  NUM_RESULTS  slot k written at least once

Behaviour:
- Reset: all outputs 0, state IDLE, last_pc 0.
- Write event: d_accept_i && |d_wr_i. Address match compares d_addr_i[31:2] only.
- last_pc register: loads pc_i whenever pc_valid_i is high, in any state.
- IDLE: counters held at 0. start_i -> RUN next cycle. start_i is ignored outside IDLE.
- RUN:
  - cycle_count increments each cycle and saturates at 32'hFFFFFFFF.
  - Interval counter counts 0..SAMPLE_INTERVAL-1 and then wraps to 0.
  - At the terminal count, the next cycle has: sample_valid_o=1, sample_pc_o=last_pc, sample_idx_o+1.
  - The first sample therefore appears SAMPLE_INTERVAL+1 cycles after start_i.
- Hang detection: a sample whose PC equals the previous sample's PC increments hang_cnt; any other PC resets it to 0. The first sample never counts. hang_cnt reaching HANG_SAMPLES moves to HANG in the same cycle as that sample pulse.
- Timeout: the sample with sample_idx == MAX_SAMPLES moves to TIMEOUT with that pulse. Hang is checked first: if both trigger on the same sample, the state is HANG.
- Marker: a write event with d_wr_i==4'hF, address MARKER_ADDR and data MARKER_VALUE moves to DONE; done_o rises the next cycle.
  - A partial-byte write or a wrong value at MARKER_ADDR does not trigger.
  - Marker has priority over a sample, hang or timeout in the same cycle; the sample pulse for that interval is suppressed.
- Result capture, RUN only: a write event at RESULT_BASE+4k (k<NUM_RESULTS) merges the enabled bytes into slot k and sets result_valid_o[k].
  - Bytes not enabled keep their value.
  - A result write in the same cycle as the marker is still captured.
  - Addresses outside the window are ignored.
- DONE/TIMEOUT/HANG: all registers frozen, no samples, writes ignored. Only clear_i leaves these states.
- clear_i: any state -> IDLE next cycle; clears counters, results, valids, cycle_count and sample_idx. Simultaneous start_i and clear_i: clear wins.
- Reset asserted mid-run: immediate asynchronous return to reset values.

Decomposition:
- Package core_run_monitor_pkg holds:
  - state enum: MON_IDLE, MON_RUN, MON_DONE, MON_TIMEOUT, MON_HANG
  - default constants: marker address, marker value, result base
  - function: byte-enable merge
- Sub-module mon_result_slot: one 32-bit byte-merge register with a valid bit, instantiated NUM_RESULTS times in a generate loop.

Test Plan:
- Defaults; start_i; pc_i increments by 4 every cycle -> sample pulses at cycles 101, 201, ... with sample_idx 1, 2, ... and PC values all distinct; no hang.
- Full write 0x80009030 = 0xDEADBEEF at RUN cycle 350 -> done_o rises at 351; cycle_count_o = 351; no further sample pulses.
- Writes 0x80009000 = 32'hFFFFFFF9 (-7), then 0x80009004 = 42 with d_wr_i=4'h3 over prior 0xAAAA0000 -> slot 0 = 0xFFFFFFF9; slot 1 = 0xAAAA002A; result_valid_o = 2'b11.
- pc_i stuck at 0x80000100 -> hang_o asserts with sample_idx_o = 9 (HANG_SAMPLES=8); result_data_o frozen afterwards.
- No marker, PC moving, MAX_SAMPLES=500 -> timeout_o with sample_idx 500 at cycle 50001; a marker write on the same cycle -> done_o instead, no pulse; a write of 0xDEADBEEF with d_wr_i=4'h7 -> ignored.
- rst low mid-RUN, then clear_i in DONE -> all outputs 0 immediately on rst; after clear_i, state_o = IDLE; a new start_i restarts sample_idx from 1.

Source files
------------

// File: rtl/core_run_monitor_pkg.sv
// core_run_monitor_pkg: shared state encoding, default bus constants and byte-merge helper
package core_run_monitor_pkg;

    typedef enum logic [2:0] {
        MON_IDLE    = 3'd0,
        MON_RUN     = 3'd1,
        MON_DONE    = 3'd2,
        MON_TIMEOUT = 3'd3,
        MON_HANG    = 3'd4
    } mon_state_e;

    localparam logic [31:0] DEF_MARKER_ADDR  = 32'h8000_9030;
    localparam logic [31:0] DEF_MARKER_VALUE = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_RESULT_BASE  = 32'h8000_9000;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/mon_result_slot.sv
// mon_result_slot: one 32-bit result word with byte-enable merge and a sticky written flag
module mon_result_slot
    import core_run_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    always_comb begin
        data_d  = clr_i ? '0 : we_i ? be_merge(data_q, data_i, be_i) : data_q;
        valid_d = clr_i ? 1'b0 : valid_q | we_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/core_run_monitor.sv
// core_run_monitor: snoops fetch PC and data writes; emits PC samples, captures results,
// and ends the run on a completion marker, a sample-count timeout or a stuck-PC hang.
module core_run_monitor
    import core_run_monitor_pkg::*;
#(
    parameter int unsigned SAMPLE_INTERVAL = 100,
    parameter int unsigned MAX_SAMPLES     = 500,
    parameter int unsigned HANG_SAMPLES    = 8,
    parameter logic [31:0] MARKER_ADDR     = DEF_MARKER_ADDR,
    parameter logic [31:0] MARKER_VALUE    = DEF_MARKER_VALUE,
    parameter logic [31:0] RESULT_BASE     = DEF_RESULT_BASE,
    parameter int unsigned NUM_RESULTS     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      clear_i,
    input  logic                      pc_valid_i,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               d_addr_i,
    input  logic [31:0]               d_data_wr_i,
    input  logic [3:0]                d_wr_i,
    input  logic                      d_accept_i,
    output logic [2:0]                state_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic                      hang_o,
    output logic [31:0]               cycle_count_o,
    output logic                      sample_valid_o,
    output logic [31:0]               sample_pc_o,
    output logic [15:0]               sample_idx_o,
    output logic [32*NUM_RESULTS-1:0] result_data_o,
    output logic [NUM_RESULTS-1:0]    result_valid_o
);

    localparam int IW = $clog2(SAMPLE_INTERVAL);
    localparam int HW = $clog2(HANG_SAMPLES + 1);

    mon_state_e  state_q, state_d;
    logic [31:0] cycle_q, cycle_d;
    logic [IW-1:0] int_q, int_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] spc_q, spc_d;
    logic        sval_q, sval_d;
    logic [HW-1:0] hang_q, hang_d;
    logic [31:0] last_pc_q;

    logic        wr_ev, marker_hit, in_run, term;
    logic [HW-1:0] hang_nxt;
    logic [15:0] idx_nxt;
    logic        is_hang, is_to;
    logic        unused_addr;

    assign unused_addr = ^d_addr_i[1:0];
    assign wr_ev       = d_accept_i && |d_wr_i;
    assign marker_hit  = wr_ev && d_wr_i == 4'hF && d_addr_i[31:2] == MARKER_ADDR[31:2]
                         && d_data_wr_i == MARKER_VALUE;
    assign in_run      = state_q == MON_RUN;
    assign term        = in_run && int_q == IW'(SAMPLE_INTERVAL - 1);
    // The first sample has no predecessor, so idx_q==0 keeps it out of the hang run
    assign hang_nxt    = (idx_q != '0 && last_pc_q == spc_q) ? hang_q + HW'(1) : '0;
    assign idx_nxt     = idx_q + 16'd1;
    assign is_hang     = hang_nxt == HW'(HANG_SAMPLES);
    assign is_to       = idx_nxt == 16'(MAX_SAMPLES);

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        int_d   = int_q;
        idx_d   = idx_q;
        spc_d   = spc_q;
        sval_d  = 1'b0;
        hang_d  = hang_q;
        if (clear_i) begin
            state_d = MON_IDLE;
            cycle_d = '0;
            int_d   = '0;
            idx_d   = '0;
            spc_d   = '0;
            hang_d  = '0;
        end else if (state_q == MON_IDLE && start_i) begin
            state_d = MON_RUN;
            cycle_d = 32'd1;
        end else if (in_run) begin
            cycle_d = &cycle_q ? cycle_q : cycle_q + 32'd1;
            int_d   = term ? '0 : int_q + IW'(1);
            // Marker wins over the sample that would close this interval
            if (marker_hit) begin
                state_d = MON_DONE;
            end else if (term) begin
                sval_d  = 1'b1;
                spc_d   = last_pc_q;
                idx_d   = idx_nxt;
                hang_d  = hang_nxt;
                state_d = is_hang ? MON_HANG : is_to ? MON_TIMEOUT : MON_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MON_IDLE;
            cycle_q   <= '0;
            int_q     <= '0;
            idx_q     <= '0;
            spc_q     <= '0;
            sval_q    <= 1'b0;
            hang_q    <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            int_q     <= int_d;
            idx_q     <= idx_d;
            spc_q     <= spc_d;
            sval_q    <= sval_d;
            hang_q    <= hang_d;
            last_pc_q <= pc_valid_i ? pc_i : last_pc_q;
        end
    end

    for (genvar k = 0; k < int'(NUM_RESULTS); k++) begin : g_slot
        logic slot_we;
        assign slot_we = in_run && wr_ev && d_addr_i[31:2] == RESULT_BASE[31:2] + 30'(k);
        mon_result_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (clear_i),
            .we_i   (slot_we),
            .be_i   (d_wr_i),
            .data_i (d_data_wr_i),
            .data_o (result_data_o[32*k +: 32]),
            .valid_o(result_valid_o[k])
        );
    end

    assign state_o        = state_q;
    assign done_o         = state_q == MON_DONE;
    assign timeout_o      = state_q == MON_TIMEOUT;
    assign hang_o         = state_q == MON_HANG;
    assign cycle_count_o  = cycle_q;
    assign sample_valid_o = sval_q;
    assign sample_pc_o    = spc_q;
    assign sample_idx_o   = idx_q;

endmodule
